// File: rtl/lock_key_loader.sv
// Key-delivery end of the logic-locking interface: shifts in a serial key plus CRC-8,
// verifies it, and commits the key to the locked core only when the checksum matches.
module lock_key_loader #(
  parameter int                KEY_W    = 25,
  parameter int                CRC_W    = 8,
  parameter logic [CRC_W-1:0]  CRC_POLY = 8'h07
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2((KEY_W > CRC_W) ? KEY_W : CRC_W);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_W - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD_KEY = 2'd1;
  localparam logic [1:0] S_LOAD_CRC = 2'd2;
  localparam logic [1:0] S_CHECK    = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [KEY_W-1:0] shadow;
  logic [CRC_W-1:0] crc;
  logic [CRC_W-1:0] rx_crc;
  logic             accept;

  // Serial handshake: a bit transfers on a rising edge where ser_valid and ser_ready
  // are both high; ser_ready depends only on state, never on ser_valid.
  assign ser_ready = (state == S_LOAD_KEY) || (state == S_LOAD_CRC);
  assign accept    = ser_valid && ser_ready;
  assign busy      = (state != S_IDLE);

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    crc_step = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      shadow    <= '0;
      crc       <= '0;
      rx_crc    <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else if (clear) begin
      state     <= S_IDLE;
      count     <= '0;
      shadow    <= '0;
      crc       <= '0;
      rx_crc    <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // A reload withdraws the old key so the core never runs on a stale one.
            state     <= S_LOAD_KEY;
            count     <= '0;
            shadow    <= '0;
            crc       <= '0;
            rx_crc    <= '0;
            err       <= 1'b0;
            key_out   <= '0;
            key_valid <= 1'b0;
          end
        end
        S_LOAD_KEY: begin
          if (accept) begin
            shadow[count] <= ser_data;
            crc           <= crc_step(crc, ser_data);
            if (count == KEY_LAST) begin
              count <= '0;
              state <= S_LOAD_CRC;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        S_LOAD_CRC: begin
          if (accept) begin
            rx_crc <= {rx_crc[CRC_W-2:0], ser_data};
            if (count == CRC_LAST) begin
              count <= '0;
              state <= S_CHECK;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (rx_crc == crc) begin
            key_out   <= shadow;
            key_valid <= 1'b1;
            err       <= 1'b0;
          end else begin
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
